// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, port ids and the
// latched request record.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  // Request record widths; the top casts into these, so keep them at least
  // as wide as the top's ADDR_W/DATA_W.
  localparam int REQ_AW = 32;
  localparam int REQ_DW = 32;

  typedef struct packed {
    logic              we;
    logic [REQ_AW-1:0] addr;
    logic [REQ_DW-1:0] wdata;
  } req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the requester not granted last wins a tie.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  input  logic       en,
  output logic [1:0] gnt
);

  assign gnt[0] = en & req[0] & (~req[1] |  last_gnt);
  assign gnt[1] = en & req[1] & (~req[0] | ~last_gnt);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the CPU path (port 0) and an auxiliary
// master (port 1): grant in IDLE, strobe in ISSUE, respond in RESP.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_valid,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_err,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_valid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            r_state;
  req_t              r_req;
  logic              r_last;
  logic              r_port;
  logic              r_err;
  logic              r_mem_re;
  logic              r_mem_we;
  logic [1:0]        r_valid;
  logic [1:0]        r_err_o;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  logic [1:0]        w_gnt;
  logic              w_port;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_err;
  logic [DATA_W-1:0] w_rsp;

  rr_arb2 u_arb (
    .req      ({r1_req, r0_req}),
    .last_gnt (r_last),
    .en       (r_state == ST_IDLE),
    .gnt      (w_gnt)
  );

  assign w_port  = w_gnt[1];
  assign w_we    = (w_port == PORT_AUX) ? r1_we    : r0_we;
  assign w_addr  = (w_port == PORT_AUX) ? r1_addr  : r0_addr;
  assign w_wdata = (w_port == PORT_AUX) ? r1_wdata : r0_wdata;

  // Checked on the winning address so the ISSUE strobes can be registered;
  // the result is latched alongside the request and reported in RESP.
  assign w_err = (w_addr[1:0] != 2'b00) || ((w_addr >> 2) >= ADDR_W'(DEPTH));

  assign w_rsp = (!r_err && !r_req.we) ? mem_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_req    <= '0;
      r_last   <= 1'b1;
      r_port   <= PORT_CPU;
      r_err    <= 1'b0;
      r_mem_re <= 1'b0;
      r_mem_we <= 1'b0;
      r_valid  <= '0;
      r_err_o  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_gnt) begin
            r_last      <= w_port;
            r_port      <= w_port;
            r_err       <= w_err;
            r_req.we    <= w_we;
            r_req.addr  <= REQ_AW'(w_addr);
            r_req.wdata <= REQ_DW'(w_wdata);
            r_mem_re    <= !w_err && !w_we;
            r_mem_we    <= !w_err &&  w_we;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_mem_re <= 1'b0;
          r_mem_we <= 1'b0;
          if (r_port == PORT_AUX) begin
            r_valid[1] <= 1'b1;
            r_err_o[1] <= r_err;
            r_rdata1   <= w_rsp;
          end else begin
            r_valid[0] <= 1'b1;
            r_err_o[0] <= r_err;
            r_rdata0   <= w_rsp;
          end
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          r_valid  <= '0;
          r_err_o  <= '0;
          r_rdata0 <= '0;
          r_rdata1 <= '0;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign r0_gnt    = w_gnt[0];
  assign r1_gnt    = w_gnt[1];
  assign r0_valid  = r_valid[0];
  assign r1_valid  = r_valid[1];
  assign r0_err    = r_err_o[0];
  assign r1_err    = r_err_o[1];
  assign r0_rdata  = r_rdata0;
  assign r1_rdata  = r_rdata1;
  assign mem_re    = r_mem_re;
  assign mem_we    = r_mem_we;
  assign mem_addr  = ADDR_W'(r_req.addr);
  assign mem_wdata = DATA_W'(r_req.wdata);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter against a transaction-level model of the
// arbiter (one access in flight, grant/strobe/response at fixed offsets).
module tb_dmem_arbiter;

  localparam int DEPTH = 32;

  logic gclk = 1'b0;
  logic rst_n = 1'b0;
  always #5 gclk = ~gclk;

  logic [1:0]       d_req = '0;
  logic [1:0]       d_we  = '0;
  logic [1:0][31:0] d_addr  = '0;
  logic [1:0][31:0] d_wdata = '0;

  logic        r0_gnt, r1_gnt, r0_valid, r1_valid, r0_err, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_re, mem_we;

  dmem_arbiter #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(gclk), .rst_n(rst_n),
    .r0_req(d_req[0]), .r0_we(d_we[0]), .r0_addr(d_addr[0]), .r0_wdata(d_wdata[0]),
    .r0_gnt(r0_gnt), .r0_valid(r0_valid), .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_req(d_req[1]), .r1_we(d_we[1]), .r1_addr(d_addr[1]), .r1_wdata(d_wdata[1]),
    .r1_gnt(r1_gnt), .r1_valid(r1_valid), .r1_rdata(r1_rdata), .r1_err(r1_err),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory seen by the DUT, and the model's own copy.
  logic [31:0] tmem    [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  bit          do_load = 1'b0;

  assign mem_rdata = ((mem_addr >> 2) < DEPTH) ? tmem[mem_addr[6:2]] : 32'h0;

  always @(posedge gclk) begin
    if (do_load) begin
      for (int i = 0; i < DEPTH; i++) tmem[i] <= ref_mem[i];
    end else if (mem_we && ((mem_addr >> 2) < DEPTH)) begin
      tmem[mem_addr[6:2]] <= mem_wdata;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transaction model: at most one access in flight, granted at cycle p_g,
  // strobed at p_g+1, answered at p_g+2; new grants only once it is done.
  int          cyc = 0;
  bit          last = 1'b1;
  bit          p_vld = 1'b0;
  int          p_g, p_port;
  bit          p_we, p_err;
  logic [31:0] p_addr, p_wdata, p_rd;
  bit   [1:0]  gnt_seen = '0;
  int          glog[$];

  bit          busy, exp_re, exp_we;
  bit   [1:0]  ev, eg;
  int          win;

  always @(negedge gclk) begin
    if (rst_n) begin
      cyc++;
      busy   = p_vld;
      exp_re = 1'b0;
      exp_we = 1'b0;
      ev     = '0;
      if (p_vld && cyc == p_g + 1) begin
        exp_re = !p_err && !p_we;
        exp_we = !p_err &&  p_we;
        chk("mem_addr", mem_addr, p_addr);
        if (p_we) chk("mem_wdata", mem_wdata, p_wdata);
        if (exp_we) ref_mem[p_addr >> 2] = p_wdata;
        p_rd = (!p_err && !p_we) ? ref_mem[p_addr >> 2] : 32'h0;
      end
      chk("mem_re", mem_re, exp_re);
      chk("mem_we", mem_we, exp_we);
      if (p_vld && cyc == p_g + 2) ev[p_port] = 1'b1;
      chk("r0_valid", r0_valid, ev[0]);
      chk("r1_valid", r1_valid, ev[1]);
      chk("r0_err",   r0_err,   ev[0] ? p_err : 1'b0);
      chk("r1_err",   r1_err,   ev[1] ? p_err : 1'b0);
      chk("r0_rdata", r0_rdata, ev[0] ? p_rd : 32'h0);
      chk("r1_rdata", r1_rdata, ev[1] ? p_rd : 32'h0);
      if (|ev) p_vld = 1'b0;

      eg = '0;
      if (!busy && (d_req != 2'b00)) begin
        win = (d_req == 2'b11) ? (last ? 0 : 1) : (d_req[1] ? 1 : 0);
        eg[win]       = 1'b1;
        last          = (win == 1);
        p_vld         = 1'b1;
        p_g           = cyc;
        p_port        = win;
        p_we          = d_we[win];
        p_addr        = d_addr[win];
        p_wdata       = d_wdata[win];
        p_err         = (p_addr % 4 != 0) || (p_addr / 4 >= DEPTH);
        gnt_seen[win] = 1'b1;
        glog.push_back(win);
      end
      chk("gnt", {r1_gnt, r0_gnt}, eg);
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {r0_gnt, r1_gnt, r0_valid, r1_valid, r0_err, r1_err, mem_re, mem_we}, 0);
    chk({tag, "_rd0"}, r0_rdata, 0);
    chk({tag, "_rd1"}, r1_rdata, 0);
    chk({tag, "_maddr"}, mem_addr, 0);
    chk({tag, "_mwdata"}, mem_wdata, 0);
  endtask

  task automatic wait_gnt(input int p);
    int k = 0;
    while (!gnt_seen[p] && k < 40) begin
      @(posedge gclk); #1;
      k++;
    end
    if (!gnt_seen[p]) chk("gnt_timeout", 0, 1);
  endtask

  task automatic issue(input int p, input bit we, input logic [31:0] a, input logic [31:0] wd);
    d_we[p] = we; d_addr[p] = a; d_wdata[p] = wd;
    gnt_seen[p] = 1'b0;
    d_req[p] = 1'b1;
    wait_gnt(p);
    d_req[p] = 1'b0;
    repeat (3) @(posedge gclk);
    #1;
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    int r;
    r = $urandom % 8;
    a = $urandom_range(0, DEPTH - 1) * 4;
    if (r == 0) a = (DEPTH + $urandom % 4) * 4;
    if (r == 1) a = a + 1 + $urandom % 3;
    if (r == 2) a = $urandom & 32'hFFFF_FFFC;
    return a;
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = $urandom;
    ref_mem[3] = 32'hDEAD_BEEF;
    do_load = 1'b1;
    @(posedge gclk); #1;
    do_load = 1'b0;
    #1;
    chk_all_zero("reset");
    @(posedge gclk); #2;
    rst_n = 1'b1;

    // Contention straight from reset: 0 wins first, then alternation.
    glog.delete();
    gnt_seen = '0;
    d_we = '0; d_addr[0] = 32'h0; d_addr[1] = 32'h4;
    d_req = 2'b11;
    repeat (13) begin
      @(posedge gclk); #1;
      for (int i = 0; i < 2; i++) begin
        if (gnt_seen[i]) begin
          gnt_seen[i] = 1'b0;
          d_we[i]    = $urandom % 2;
          d_addr[i]  = $urandom_range(0, DEPTH - 1) * 4;
          d_wdata[i] = $urandom;
        end
      end
    end
    d_req = '0;
    repeat (4) @(posedge gclk);
    #1;
    chk("cont_cnt", glog.size() >= 4, 1);
    if (glog.size() >= 4)
      for (int k = 0; k < 4; k++) chk("cont_order", glog[k], k % 2);

    // Directed accesses, including both range boundaries.
    issue(0, 1'b0, 32'h0C, 32'h0);
    issue(1, 1'b1, 32'h7C, 32'h1234_5678);
    issue(1, 1'b0, 32'h7C, 32'h0);
    issue(0, 1'b0, 32'h02, 32'h0);
    issue(1, 1'b1, 32'h80, 32'hFFFF_FFFF);
    issue(0, 1'b0, 32'h7C, 32'h0);

    // Random traffic from both ports.
    gnt_seen = '0;
    repeat (400) begin
      @(posedge gclk); #1;
      for (int i = 0; i < 2; i++) begin
        if (gnt_seen[i]) begin
          gnt_seen[i] = 1'b0;
          d_req[i]    = 1'b0;
        end
        if (!d_req[i] && ($urandom % 3 == 0)) begin
          d_we[i]    = $urandom % 2;
          d_addr[i]  = rnd_addr();
          d_wdata[i] = $urandom;
          d_req[i]   = 1'b1;
        end
      end
    end
    d_req = '0;
    repeat (4) @(posedge gclk);
    #1;

    // Asynchronous reset while a write to 0x10 is in ISSUE.
    d_we[0] = 1'b1; d_addr[0] = 32'h10; d_wdata[0] = 32'hA5A5_5A5A;
    gnt_seen = '0;
    d_req[0] = 1'b1;
    wait_gnt(0);
    d_req[0] = 1'b0;
    chk("issue_we", mem_we, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_we_drop", mem_we, 0);
    chk_all_zero("midrst");
    p_vld = 1'b0;
    last  = 1'b1;
    repeat (2) @(posedge gclk);
    #2;
    rst_n = 1'b1;
    glog.delete();
    gnt_seen = '0;
    d_we = '0; d_addr[0] = 32'h10; d_addr[1] = 32'h14;
    d_req = 2'b11;
    @(posedge gclk); #1;
    d_req = '0;
    chk("rst_tie", (glog.size() > 0) ? glog[0] : 9, 0);
    repeat (4) @(posedge gclk);
    #1;

    for (int i = 0; i < DEPTH; i++) chk("mem_final", tmem[i], ref_mem[i]);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
